// File: rtl/spi_master_sequencer.sv
// SPI master transaction sequencer: one read or write request at a time, framed as
// 7-bit address + rw bit, optional turnaround, then 8 data bits; one-cycle response.
module spi_master_sequencer #(
    parameter int CLK_DIV   = 2,
    parameter int TURN_BITS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       cs,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [2:0] {IDLE, ADDR, TURN, RDATA, WDATA, HOLD, RESP} state_t;

    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW = (TURN_BITS > 1) ? $clog2(TURN_BITS) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
    localparam logic [TW-1:0] T_LAST = TW'((TURN_BITS > 0) ? TURN_BITS - 1 : 0);

    state_t        state_r, state_s;
    logic [HW-1:0] hcnt_r, hcnt_s;
    logic          phase_r, phase_s;
    logic [2:0]    bcnt_r, bcnt_s;
    logic [TW-1:0] tcnt_r, tcnt_s;
    logic          rw_r;
    logic [6:0]    addr_r;
    logic [7:0]    wdata_r;
    logic [7:0]    shift_r;

    logic          accept_s, half_end_s, bit_end_s, sample_s, shifting_s, mosi_s;
    logic          rw_cap_s;
    logic [6:0]    addr_cap_s;
    logic [7:0]    wdata_cap_s;

    // Next-state logic: half-period, bit and turnaround counters plus phase sequencing
    always_comb begin
        state_s    = state_r;
        hcnt_s     = hcnt_r;
        phase_s    = phase_r;
        bcnt_s     = bcnt_r;
        tcnt_s     = tcnt_r;
        accept_s   = (state_r == IDLE) && req_ready && req_valid;
        half_end_s = (hcnt_r == H_LAST);
        bit_end_s  = half_end_s && phase_r;
        sample_s   = (state_r == RDATA) && half_end_s && !phase_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = ADDR;
                    hcnt_s  = '0;
                    phase_s = 1'b0;
                    bcnt_s  = 3'd0;
                    tcnt_s  = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR, TURN, RDATA, WDATA: begin
                if (half_end_s) begin
                    hcnt_s  = '0;
                    phase_s = !phase_r;
                end else begin
                    hcnt_s = hcnt_r + HW'(1);
                end
                if (bit_end_s) begin
                    case (state_r)
                        ADDR: begin
                            if (bcnt_r == 3'd7) begin
                                bcnt_s  = 3'd0;
                                state_s = rw_r ? ((TURN_BITS > 0) ? TURN : RDATA) : WDATA;
                            end else begin
                                bcnt_s = bcnt_r + 3'd1;
                            end
                        end
                        TURN: begin
                            if (tcnt_r == T_LAST) begin
                                tcnt_s  = '0;
                                state_s = RDATA;
                            end else begin
                                tcnt_s = tcnt_r + TW'(1);
                            end
                        end
                        default: begin
                            if (bcnt_r == 3'd7) begin
                                bcnt_s  = 3'd0;
                                state_s = HOLD;
                            end else begin
                                bcnt_s = bcnt_r + 3'd1;
                            end
                        end
                    endcase
                end else begin
                    bcnt_s = bcnt_r;
                end
            end
            HOLD: begin
                phase_s = 1'b0;
                if (half_end_s) begin
                    hcnt_s  = '0;
                    state_s = RESP;
                end else begin
                    hcnt_s = hcnt_r + HW'(1);
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Serial data for the next cycle; on the accept edge the request inputs feed the first bit
    always_comb begin
        rw_cap_s    = accept_s ? req_rw    : rw_r;
        addr_cap_s  = accept_s ? req_addr  : addr_r;
        wdata_cap_s = accept_s ? req_wdata : wdata_r;
        shifting_s  = (state_s == ADDR) || (state_s == TURN) ||
                      (state_s == RDATA) || (state_s == WDATA);
        case (state_s)
            ADDR:    mosi_s = (bcnt_s == 3'd7) ? rw_cap_s : addr_cap_s[3'd6 - bcnt_s];
            WDATA:   mosi_s = wdata_cap_s[3'd7 - bcnt_s];
            default: mosi_s = 1'b0;
        endcase
    end

    // State, capture and output registers; all pins come straight from flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            hcnt_r    <= '0;
            phase_r   <= 1'b0;
            bcnt_r    <= 3'd0;
            tcnt_r    <= '0;
            rw_r      <= 1'b0;
            addr_r    <= 7'd0;
            wdata_r   <= 8'd0;
            shift_r   <= 8'd0;
            cs        <= 1'b1;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'd0;
        end else begin
            state_r <= state_s;
            hcnt_r  <= hcnt_s;
            phase_r <= phase_s;
            bcnt_r  <= bcnt_s;
            tcnt_r  <= tcnt_s;
            if (accept_s) begin
                rw_r    <= req_rw;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                shift_r <= 8'd0;
            end else if (sample_s) begin
                shift_r <= {shift_r[6:0], miso};
            end
            cs        <= !shifting_s;
            sclk      <= shifting_s && phase_s;
            mosi      <= mosi_s;
            req_ready <= (state_s == IDLE);
            busy      <= (state_s != IDLE);
            rsp_valid <= (state_s == RESP);
            if (state_s == RESP) begin
                rsp_rdata <= rw_r ? shift_r : 8'h00;
            end
        end
    end

endmodule
